// File: rtl/apb_master_2s.sv
// apb_master_2s: APB requester for a two-slave segment, one command per IDLE->SETUP->ACCESS.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without PREADY.
module apb_master_2s #(
   parameter int unsigned ADDR_W         = 8,
   parameter int unsigned DATA_W         = 8,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              REQ_VALID,
   output logic              REQ_READY,
   input  logic              REQ_WRITE,
   input  logic [ADDR_W:0]   REQ_ADDR,
   input  logic [DATA_W-1:0] REQ_WDATA,
   output logic              RSP_VALID,
   output logic [DATA_W-1:0] RSP_RDATA,
   output logic              RSP_ERR,
   output logic              PSEL1,
   output logic              PSEL2,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA1,
   input  logic [DATA_W-1:0] PRDATA2,
   input  logic              PREADY1,
   input  logic              PREADY2
);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

   state_e              state_q, state_d;
   logic                sel2_q, sel2_d;
   logic                pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic                psel1_q, psel2_q, penable_q, req_ready_q;
   logic                psel1_d, psel2_d, penable_d, req_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;

   logic                sel_ready;
   logic [DATA_W-1:0]   sel_rdata;

   // Only the latched slave's handshake is looked at.
   assign sel_ready = sel2_q ? PREADY2 : PREADY1;
   assign sel_rdata = sel2_q ? PRDATA2 : PRDATA1;

`ifdef APB_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d     = state_q;
      sel2_d      = sel2_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (REQ_VALID) begin
               sel2_d   = REQ_ADDR[ADDR_W];
               pwrite_d = REQ_WRITE;
               paddr_d  = REQ_ADDR[ADDR_W-1:0];
               pwdata_d = REQ_WDATA;
               state_d  = StSetup;
            end
         end
         StSetup: begin
            state_d = StAccess;
`ifdef APB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         StAccess: begin
            if (sel_ready) begin
               state_d     = StIdle;
               rsp_valid_d = 1'b1;
               if (!pwrite_q) begin
                  rsp_rdata_d = sel_rdata;
               end
`ifdef APB_TIMEOUT_EN
            end else if (cnt_q == CntLast) begin
               state_d     = StIdle;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Bus controls are derived from the next state so every output comes straight off a flop.
   assign psel1_d     = (state_d != StIdle) && !sel2_d;
   assign psel2_d     = (state_d != StIdle) && sel2_d;
   assign penable_d   = (state_d == StAccess);
   assign req_ready_d = (state_d == StIdle);

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= StIdle;
         sel2_q      <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         psel1_q     <= 1'b0;
         psel2_q     <= 1'b0;
         penable_q   <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel2_q      <= sel2_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         psel1_q     <= psel1_d;
         psel2_q     <= psel2_d;
         penable_q   <= penable_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign REQ_READY = req_ready_q;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_RDATA = rsp_rdata_q;
   assign RSP_ERR   = rsp_err_q;
   assign PSEL1     = psel1_q;
   assign PSEL2     = psel2_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;

endmodule
